// File: rtl/alu_op_issuer_if.sv
//------------------------------------------------------------------------------
// alu_op_issuer_if
// Request, response and ALU-control bundle for alu_op_issuer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface alu_op_issuer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int SHIFT_AMT  = $clog2(DATA_WIDTH)
);
    logic                  req_valid;
    logic                  req_ready;
    logic [3:0]            req_op;
    logic [DATA_WIDTH-1:0] req_a;
    logic [DATA_WIDTH-1:0] req_b;
    logic [SHIFT_AMT-1:0]  req_shamt;

    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [SHIFT_AMT-1:0]  alu_shift_code;
    logic                  alu_invert_a;
    logic                  alu_invert_b;
    logic                  alu_invert_out;
    logic                  alu_or_enable;
    logic                  alu_carry_in;
    logic [DATA_WIDTH-1:0] alu_data_out;
    logic                  alu_carry_out;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_carry;
    logic                  rsp_err;
    logic                  carry_flag;

    modport master (
        output req_valid, req_op, req_a, req_b, req_shamt, rsp_ready,
               alu_data_out, alu_carry_out,
        input  req_ready, alu_a, alu_b, alu_shift_code, alu_invert_a,
               alu_invert_b, alu_invert_out, alu_or_enable, alu_carry_in,
               rsp_valid, rsp_data, rsp_carry, rsp_err, carry_flag
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_shamt, rsp_ready,
               alu_data_out, alu_carry_out,
        output req_ready, alu_a, alu_b, alu_shift_code, alu_invert_a,
               alu_invert_b, alu_invert_out, alu_or_enable, alu_carry_in,
               rsp_valid, rsp_data, rsp_carry, rsp_err, carry_flag
    );
endinterface

`default_nettype wire

// File: rtl/alu_op_issuer.sv
//------------------------------------------------------------------------------
// alu_op_issuer
// Decodes ALU requests, sequences ALU passes and returns result/carry.
// Optional multi-pass XOR enabled by macro ALU_ISSUE_XOR_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_op_issuer #(
    parameter int DATA_WIDTH = 64,
    parameter int SHIFT_AMT  = $clog2(DATA_WIDTH)
) (
    input  wire logic       clk,
    input  wire logic       rst,
    alu_op_issuer_if.slave  bus
);

    localparam logic [3:0] c_OP_ADD   = 4'd0;
    localparam logic [3:0] c_OP_SUB   = 4'd1;
    localparam logic [3:0] c_OP_ADC   = 4'd2;
    localparam logic [3:0] c_OP_SBC   = 4'd3;
    localparam logic [3:0] c_OP_OR    = 4'd4;
    localparam logic [3:0] c_OP_AND   = 4'd5;
    localparam logic [3:0] c_OP_NOR   = 4'd6;
    localparam logic [3:0] c_OP_NAND  = 4'd7;
    localparam logic [3:0] c_OP_SHIFT = 4'd8;
`ifdef ALU_ISSUE_XOR_EN
    localparam logic [3:0] c_OP_XOR   = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_EXEC = 3'd1, S_X1 = 3'd2, S_X2 = 3'd3, S_X3 = 3'd4, S_RESP = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_EXEC = 3'd1, S_RESP = 3'd5
    } state_t;
`endif

    state_t r_state, w_state_next;

    logic w_inv_a, w_inv_b, w_inv_out, w_or_en, w_cin, w_legal, w_is_shift, w_is_arith;
    logic w_accept;
`ifdef ALU_ISSUE_XOR_EN
    logic                  w_is_xor;
    logic [DATA_WIDTH-1:0] r_t1, r_t2;
`endif

    logic [DATA_WIDTH-1:0] r_a, r_b, r_rsp_data;
    logic [SHIFT_AMT-1:0]  r_shamt;
    logic r_inv_a, r_inv_b, r_inv_out, r_or_en, r_cin, r_arith;
    logic r_rsp_carry, r_rsp_err, r_carry_flag;

    // Opcode decode; ADC/SBC fold the architectural carry in at accept time.
    always_comb begin
        w_inv_a    = 1'b0;
        w_inv_b    = 1'b0;
        w_inv_out  = 1'b0;
        w_or_en    = 1'b0;
        w_cin      = 1'b0;
        w_legal    = 1'b1;
        w_is_shift = 1'b0;
`ifdef ALU_ISSUE_XOR_EN
        w_is_xor   = 1'b0;
`endif
        case (bus.req_op)
            c_OP_ADD:   ;
            c_OP_SUB:   begin w_inv_b = 1'b1; w_cin = 1'b1; end
            c_OP_ADC:   w_cin = r_carry_flag;
            c_OP_SBC:   begin w_inv_b = 1'b1; w_cin = r_carry_flag; end
            c_OP_OR:    w_or_en = 1'b1;
            c_OP_AND:   begin w_inv_a = 1'b1; w_inv_b = 1'b1; w_inv_out = 1'b1; w_or_en = 1'b1; end
            c_OP_NOR:   begin w_inv_out = 1'b1; w_or_en = 1'b1; end
            c_OP_NAND:  begin w_inv_a = 1'b1; w_inv_b = 1'b1; w_or_en = 1'b1; end
            c_OP_SHIFT: begin w_or_en = 1'b1; w_is_shift = 1'b1; end
`ifdef ALU_ISSUE_XOR_EN
            c_OP_XOR:   w_is_xor = 1'b1;
`endif
            default:    w_legal = 1'b0;
        endcase
    end

    assign w_is_arith = (bus.req_op[3:2] == 2'b00);
    assign w_accept   = (r_state == S_IDLE) && bus.req_valid;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next       = r_state;
        bus.req_ready      = 1'b0;
        bus.rsp_valid      = 1'b0;
        bus.alu_a          = '0;
        bus.alu_b          = '0;
        bus.alu_shift_code = '0;
        bus.alu_invert_a   = 1'b0;
        bus.alu_invert_b   = 1'b0;
        bus.alu_invert_out = 1'b0;
        bus.alu_or_enable  = 1'b0;
        bus.alu_carry_in   = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (!w_legal)      w_state_next = S_RESP;
`ifdef ALU_ISSUE_XOR_EN
                    else if (w_is_xor) w_state_next = S_X1;
`endif
                    else               w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                bus.alu_a          = r_a;
                bus.alu_b          = r_b;
                bus.alu_shift_code = r_shamt;
                bus.alu_invert_a   = r_inv_a;
                bus.alu_invert_b   = r_inv_b;
                bus.alu_invert_out = r_inv_out;
                bus.alu_or_enable  = r_or_en;
                bus.alu_carry_in   = r_cin;
                w_state_next       = S_RESP;
            end
`ifdef ALU_ISSUE_XOR_EN
            // a^b = (a|b) & (~a|~b); the AND is formed as ~(~t1|~t2).
            S_X1: begin
                bus.alu_a         = r_a;
                bus.alu_b         = r_b;
                bus.alu_or_enable = 1'b1;
                w_state_next      = S_X2;
            end
            S_X2: begin
                bus.alu_a         = r_a;
                bus.alu_b         = r_b;
                bus.alu_invert_a  = 1'b1;
                bus.alu_invert_b  = 1'b1;
                bus.alu_or_enable = 1'b1;
                w_state_next      = S_X3;
            end
            S_X3: begin
                bus.alu_a          = r_t1;
                bus.alu_b          = r_t2;
                bus.alu_invert_a   = 1'b1;
                bus.alu_invert_b   = 1'b1;
                bus.alu_invert_out = 1'b1;
                bus.alu_or_enable  = 1'b1;
                w_state_next       = S_RESP;
            end
`endif
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0; r_b <= '0; r_shamt <= '0;
            r_inv_a <= 1'b0; r_inv_b <= 1'b0; r_inv_out <= 1'b0;
            r_or_en <= 1'b0; r_cin <= 1'b0; r_arith <= 1'b0;
            r_rsp_data <= '0; r_rsp_carry <= 1'b0; r_rsp_err <= 1'b0;
            r_carry_flag <= 1'b0;
`ifdef ALU_ISSUE_XOR_EN
            r_t1 <= '0; r_t2 <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_a       <= bus.req_a;
                    r_b       <= w_is_shift ? '0 : bus.req_b;
                    r_shamt   <= w_is_shift ? bus.req_shamt : '0;
                    r_inv_a   <= w_inv_a;
                    r_inv_b   <= w_inv_b;
                    r_inv_out <= w_inv_out;
                    r_or_en   <= w_or_en;
                    r_cin     <= w_cin;
                    r_arith   <= w_is_arith;
                    if (!w_legal) begin
                        r_rsp_data  <= '0;
                        r_rsp_carry <= 1'b0;
                        r_rsp_err   <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_rsp_data  <= bus.alu_data_out;
                    r_rsp_carry <= r_arith & bus.alu_carry_out;
                    r_rsp_err   <= 1'b0;
                    if (r_arith) r_carry_flag <= bus.alu_carry_out;
                end
`ifdef ALU_ISSUE_XOR_EN
                S_X1: r_t1 <= bus.alu_data_out;
                S_X2: r_t2 <= bus.alu_data_out;
                S_X3: begin
                    r_rsp_data  <= bus.alu_data_out;
                    r_rsp_carry <= 1'b0;
                    r_rsp_err   <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_carry  = r_rsp_carry;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.carry_flag = r_carry_flag;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_issuer.sv
//------------------------------------------------------------------------------
// tb_alu_op_issuer
// Directed and random checks of alu_op_issuer against an arithmetic model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_op_issuer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic cf_m    = 1'b0;

    always #5 clk = ~clk;

    alu_op_issuer_if #(.DATA_WIDTH(64)) bus ();

    alu_op_issuer #(.DATA_WIDTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ALU: optional input inversion, OR or add, left shift, optional output inversion.
    always_comb begin
        logic [63:0] a2, b2, r;
        logic [64:0] s;
        logic        c;
        a2 = bus.alu_invert_a ? ~bus.alu_a : bus.alu_a;
        b2 = bus.alu_invert_b ? ~bus.alu_b : bus.alu_b;
        s  = '0;
        c  = 1'b0;
        if (bus.alu_or_enable) begin
            r = a2 | b2;
        end else begin
            s = {1'b0, a2} + {1'b0, b2} + {64'd0, bus.alu_carry_in};
            r = s[63:0];
            c = s[64];
        end
        r = r << bus.alu_shift_code;
        bus.alu_data_out  = bus.alu_invert_out ? ~r : r;
        bus.alu_carry_out = c;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic alu_active();
        return |{bus.alu_a, bus.alu_b, bus.alu_shift_code, bus.alu_invert_a, bus.alu_invert_b,
                 bus.alu_invert_out, bus.alu_or_enable, bus.alu_carry_in};
    endfunction

    function automatic logic [4:0] exp_ctrl(input logic [3:0] op, input logic cf);
        case (op)
            4'd0:    return 5'b00000;
            4'd1:    return 5'b01001;
            4'd2:    return {4'b0000, cf};
            4'd3:    return {4'b0100, cf};
            4'd4:    return 5'b00010;
            4'd5:    return 5'b11110;
            4'd6:    return 5'b00110;
            4'd7:    return 5'b11010;
            4'd8:    return 5'b00010;
            default: return 5'b00000;
        endcase
    endfunction

    // Architectural result of each opcode; carry is the adder carry (no-borrow for subtracts).
    task automatic model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [5:0] sh, input logic cf,
                         output logic [63:0] d, output logic c, output logic e, output logic ncf);
        logic [64:0] w;
        d = '0; c = 1'b0; e = 1'b0; ncf = cf;
        case (op)
            4'd0: begin w = {1'b0, a} + {1'b0, b}; d = w[63:0]; c = w[64]; end
            4'd1: begin d = a - b; c = (a >= b); end
            4'd2: begin w = {1'b0, a} + {1'b0, b} + {64'd0, cf}; d = w[63:0]; c = w[64]; end
            4'd3: begin d = a - b - {63'd0, !cf}; c = ({1'b0, a} >= {1'b0, b} + {64'd0, !cf}); end
            4'd4: d = a | b;
            4'd5: d = a & b;
            4'd6: d = ~(a | b);
            4'd7: d = ~(a & b);
            4'd8: d = a << sh;
`ifdef ALU_ISSUE_XOR_EN
            4'd9: d = a ^ b;
`endif
            default: e = 1'b1;
        endcase
        if (op <= 4'd3) ncf = c;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [5:0] sh, input int stall);
        logic [63:0] ed;
        logic        ec, ee, ncf;
        int          lat, passes, exp_lat;
        model(op, a, b, sh, cf_m, ed, ec, ee, ncf);
        exp_lat = ee ? 0 : (op == 4'd9) ? 3 : 1;
        @(negedge clk);
        chk("req_ready_idle", {63'd0, bus.req_ready}, 64'd1);
        chk("alu_zero_idle", {63'd0, alu_active()}, 64'd0);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_shamt = sh;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0; passes = 0;
        while (!bus.rsp_valid && lat < 20) begin
            chk("req_ready_busy", {63'd0, bus.req_ready}, 64'd0);
            if (bus.alu_or_enable) passes++;
            if (lat == 0 && exp_lat == 1) begin
                chk("alu_ctrl", {59'd0, bus.alu_invert_a, bus.alu_invert_b, bus.alu_invert_out,
                                 bus.alu_or_enable, bus.alu_carry_in}, {59'd0, exp_ctrl(op, cf_m)});
                chk("alu_a", bus.alu_a, a);
                chk("alu_b", bus.alu_b, (op == 4'd8) ? 64'd0 : b);
                chk("alu_shift", {58'd0, bus.alu_shift_code}, (op == 4'd8) ? {58'd0, sh} : 64'd0);
            end
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        if (op == 4'd9 && !ee) chk("xor_passes", 64'(passes), 64'd3);
        chk("rsp_data", bus.rsp_data, ed);
        chk("rsp_carry", {63'd0, bus.rsp_carry}, {63'd0, ec});
        chk("rsp_err", {63'd0, bus.rsp_err}, {63'd0, ee});
        chk("carry_flag", {63'd0, bus.carry_flag}, {63'd0, ncf});
        chk("alu_zero_resp", {63'd0, alu_active()}, 64'd0);
        for (int i = 0; i < stall; i++) begin
            bus.req_valid = 1'b1;
            bus.req_op    = 4'd0;
            @(posedge clk); #1;
            chk("stall_valid", {63'd0, bus.rsp_valid}, 64'd1);
            chk("stall_data", bus.rsp_data, ed);
            chk("stall_ready", {63'd0, bus.req_ready}, 64'd0);
            chk("stall_cf", {63'd0, bus.carry_flag}, {63'd0, ncf});
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("post_hs_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("post_hs_ready", {63'd0, bus.req_ready}, 64'd1);
        bus.req_valid = 1'b0;
        cf_m = ncf;
    endtask

    task automatic chk_reset_state();
        chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("rst_alu_zero", {63'd0, alu_active()}, 64'd0);
        chk("rst_carry_flag", {63'd0, bus.carry_flag}, 64'd0);
    endtask

    initial begin
        logic [63:0] ra, rb;
        logic [3:0]  rop;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
        bus.req_shamt = '0; bus.rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_state();
        chk("rst_rsp_data", bus.rsp_data, 64'd0);
        chk("rst_rsp_carry", {63'd0, bus.rsp_carry}, 64'd0);
        chk("rst_rsp_err", {63'd0, bus.rsp_err}, 64'd0);
        @(negedge clk); rst = 1'b0;

        do_op(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 0);
        do_op(4'd2, 64'd5, 64'd7, 6'd0, 0);
        do_op(4'd9, 64'hF0F0, 64'hFF00, 6'd0, 1);
        do_op(4'd12, 64'h1234, 64'h5678, 6'd0, 0);
        do_op(4'd1, 64'd3, 64'd5, 6'd0, 10);
        do_op(4'd3, 64'd10, 64'd4, 6'd0, 0);
        do_op(4'd8, 64'h8000_0000_0000_0001, 64'hFFFF, 6'd63, 2);
        do_op(4'd5, 64'hFF00_FF00_1234_5678, 64'h0F0F_0F0F_FFFF_0000, 6'd0, 0);

        // Set carry, then reset mid-operation.
        do_op(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd0, 0);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 4'd9; bus.req_a = 64'h55; bus.req_b = 64'h0F;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
`ifdef ALU_ISSUE_XOR_EN
        @(posedge clk); #1;
        chk("x2_inv_a", {63'd0, bus.alu_invert_a}, 64'd1);
`endif
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_state();
        @(negedge clk); rst = 1'b0;
        cf_m = 1'b0;

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       begin ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; end
                1:       begin ra = '1; rb = {$urandom, $urandom}; end
                2:       begin ra = 64'd0; rb = 64'(~{$urandom, $urandom}); end
                default: begin ra = 64'($urandom_range(0, 9)); rb = 64'($urandom_range(0, 9)); end
            endcase
            do_op(rop, ra, rb, 6'($urandom_range(0, 63)), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
